// File: rtl/intercon_arbiter_pkg.sv
// Shared definitions for the Wishbone master-port arbiter: bus widths,
// arbiter FSM states and a helper for sizing the watchdog counter.
package intercon_arbiter_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } arb_state_e;

    // The watchdog only has to count up to TIMEOUT_CYCLES-1 before it fires;
    // a disabled watchdog still needs a legal one-bit counter.
    function automatic int wdog_width(input int timeout);
        if (timeout < 2) begin
            return 1;
        end
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/intercon_rr_pick.sv
// Combinational round-robin picker. Given the request vector and the one-hot
// pointer of the last winner, returns a one-hot grant for the first requester
// strictly after the last winner, wrapping around to bit 0.
module intercon_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] last_i,
    output logic [N-1:0] gnt_o
);

    logic [N-1:0] above_mask;
    logic [N-1:0] req_above;
    logic [N-1:0] pick_src;

    // Prefer requesters above the last winner; if none, wrap and take the
    // lowest requester overall. Lowest set bit is isolated with x & -x.
    always_comb begin
        above_mask = ~(last_i | (last_i - 1'b1));
        req_above  = req_i & above_mask;
        pick_src   = (req_above != '0) ? req_above : req_i;
        gnt_o      = pick_src & (~pick_src + 1'b1);
    end

endmodule

// File: rtl/intercon_arbiter.sv
// Round-robin, whole-cycle arbiter for the single Wishbone master port of the
// interconnect. A granted master owns the bus until it drops cyc; a per-beat
// watchdog turns a hung stb into a one-cycle error back to the requester.
module intercon_arbiter
    import intercon_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel_i,
    input  logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr_i,
    input  logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_i,
    output logic [WB_DAT_W-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic                            bus_cyc_o,
    output logic                            bus_stb_o,
    output logic                            bus_we_o,
    output logic [WB_SEL_W-1:0]             bus_sel_o,
    output logic [WB_ADR_W-1:0]             bus_adr_o,
    output logic [WB_DAT_W-1:0]             bus_dat_o,
    input  logic [WB_DAT_W-1:0]             bus_dat_i,
    input  logic                            bus_ack_i,
    output logic [NUM_MASTERS-1:0]          grant_o
);

    localparam int WD_W = wdog_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_MASTERS-1:0] LAST_RESET =
        {1'b1, {(NUM_MASTERS-1){1'b0}}};

    arb_state_e              state_q, state_d;
    logic [NUM_MASTERS-1:0]  grant_q, grant_d;
    logic [NUM_MASTERS-1:0]  last_q, last_d;
    logic [WD_W-1:0]         wdog_q, wdog_d;
    logic [NUM_MASTERS-1:0]  pick_gnt;

    logic                    g_cyc;
    logic                    g_stb;
    logic                    g_we;
    logic [WB_SEL_W-1:0]     g_sel;
    logic [WB_ADR_W-1:0]     g_adr;
    logic [WB_DAT_W-1:0]     g_dat;

    intercon_rr_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .req_i  (m_cyc_i),
        .last_i (last_q),
        .gnt_o  (pick_gnt)
    );

    // Select the granted master's request signals; grant is one-hot or zero.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_sel = '0;
        g_adr = '0;
        g_dat = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                g_cyc = m_cyc_i[k];
                g_stb = m_stb_i[k];
                g_we  = m_we_i[k];
                g_sel = m_sel_i[WB_SEL_W*k +: WB_SEL_W];
                g_adr = m_adr_i[WB_ADR_W*k +: WB_ADR_W];
                g_dat = m_dat_i[WB_DAT_W*k +: WB_DAT_W];
            end
        end
    end

    // Bus and requester outputs are decoded from the registered state so a
    // reset removes them immediately, without waiting for a clock edge.
    always_comb begin
        bus_cyc_o = 1'b0;
        bus_stb_o = 1'b0;
        bus_we_o  = 1'b0;
        bus_sel_o = '0;
        bus_adr_o = '0;
        bus_dat_o = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        case (state_q)
            ST_BUSY: begin
                bus_cyc_o = g_cyc;
                bus_stb_o = g_cyc & g_stb;
                bus_we_o  = g_we;
                bus_sel_o = g_sel;
                bus_adr_o = g_adr;
                bus_dat_o = g_dat;
                m_ack_o   = grant_q & {NUM_MASTERS{bus_ack_i}};
            end
            ST_ERR: begin
                m_err_o = grant_q;
            end
            default: begin
            end
        endcase
    end

    assign m_dat_o = bus_dat_i;
    assign grant_o = grant_q;

    // Next-state logic: arbitrate in IDLE, hold the grant through BUSY until
    // cyc drops, and run the stb-without-ack watchdog during BUSY.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                wdog_d  = '0;
                if (|m_cyc_i) begin
                    grant_d = pick_gnt;
                    last_d  = pick_gnt;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    wdog_d  = '0;
                end else if (!g_stb || bus_ack_i) begin
                    wdog_d = '0;
                end else if ((TIMEOUT_CYCLES != 0) && (wdog_q == WD_LAST)) begin
                    state_d = ST_ERR;
                    wdog_d  = '0;
                end else if (wdog_q != '1) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                grant_d = '0;
                wdog_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                wdog_d  = '0;
            end
        endcase
    end

    // State registers; the pointer resets to the top master so master 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RESET;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_intercon_arbiter.sv
// Testbench for intercon_arbiter: directed scenarios followed by randomized
// transfers, all checked against a transaction-level round-robin model.
module tb_intercon_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 4;

    logic             clk;
    logic             rst;
    logic [N-1:0]     m_cyc;
    logic [N-1:0]     m_stb;
    logic [N-1:0]     m_we;
    logic [4*N-1:0]   m_sel;
    logic [32*N-1:0]  m_adr;
    logic [32*N-1:0]  m_dat;
    logic [31:0]      m_dat_o;
    logic [N-1:0]     m_ack_o;
    logic [N-1:0]     m_err_o;
    logic             bus_cyc_o;
    logic             bus_stb_o;
    logic             bus_we_o;
    logic [3:0]       bus_sel_o;
    logic [31:0]      bus_adr_o;
    logic [31:0]      bus_dat_o;
    logic [31:0]      bus_dat_in;
    logic             bus_ack_in;
    logic [N-1:0]     grant_o;

    int total_checks;
    int pass_checks;
    int fail_checks;
    int last_idx;

    intercon_arbiter #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_sel_i   (m_sel),
        .m_adr_i   (m_adr),
        .m_dat_i   (m_dat),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .bus_cyc_o (bus_cyc_o),
        .bus_stb_o (bus_stb_o),
        .bus_we_o  (bus_we_o),
        .bus_sel_o (bus_sel_o),
        .bus_adr_o (bus_adr_o),
        .bus_dat_o (bus_dat_o),
        .bus_dat_i (bus_dat_in),
        .bus_ack_i (bus_ack_in),
        .grant_o   (grant_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) pass_checks++;
        else begin
            fail_checks++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first requester after the last winner, modulo N.
    function automatic int model_pick(input logic [N-1:0] mask);
        for (int off = 1; off <= N; off++) begin
            int idx;
            idx = (last_idx + off) % N;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    // Mostly beats that complete in time, sometimes a slave that hangs.
    function automatic int random_latency();
        int r;
        r = int'($urandom_range(0, 9));
        return (r < 8) ? (r % 4) : (TIMEOUT + (r % 2));
    endfunction

    task automatic load_master(input int k, input bit directed);
        if (directed) begin
            m_we[k]             = 1'b1;
            m_sel[4*k +: 4]     = 4'hF;
            m_adr[32*k +: 32]   = 32'h0030_0010;
            m_dat[32*k +: 32]   = 32'hDEAD_BEEF;
        end else begin
            m_we[k]             = 1'($urandom_range(0, 1));
            m_sel[4*k +: 4]     = 4'($urandom_range(0, 15));
            m_adr[32*k +: 32]   = $urandom();
            m_dat[32*k +: 32]   = $urandom();
        end
    endtask

    // One whole transfer: called just after an edge with the arbiter idle.
    // fixed_lat < 0 draws a random wait count per beat; gap inserts stb-low
    // cycles before each beat.
    task automatic applyStimulus(input logic [N-1:0] mask, input int beats,
                                 input int fixed_lat, input int gap, input bit directed);
        int           w;
        int           lat;
        int           waits;
        bit           errored;
        logic [N-1:0] wmask;
        logic [31:0]  rdata;
        for (int k = 0; k < N; k++) begin
            m_cyc[k] = mask[k];
            m_stb[k] = mask[k];
            if (mask[k]) begin
                load_master(k, directed);
            end else begin
                m_we[k]           = 1'b0;
                m_sel[4*k +: 4]   = '0;
                m_adr[32*k +: 32] = '0;
                m_dat[32*k +: 32] = '0;
            end
        end
        bus_ack_in = 1'b0;
        w = model_pick(mask);
        @(negedge clk);
        checkOutput("idle_grant", 32'(grant_o), 32'h0);
        checkOutput("idle_bus_cyc", 32'(bus_cyc_o), 32'h0);
        tick();
        last_idx = w;
        wmask    = '0;
        wmask[w] = 1'b1;
        errored  = 1'b0;
        for (int b = 0; b < beats && !errored; b++) begin
            if (b > 0 && !directed) load_master(w, 1'b0);
            lat = (fixed_lat >= 0) ? fixed_lat : random_latency();
            for (int g = 0; g < gap; g++) begin
                m_stb[w] = 1'b0;
                @(negedge clk);
                checkOutput("gap_stb", 32'(bus_stb_o), 32'h0);
                checkOutput("gap_err", 32'(m_err_o), 32'h0);
                checkOutput("gap_grant", 32'(grant_o), 32'(wmask));
                tick();
            end
            m_stb[w] = 1'b1;
            waits = 0;
            while (waits < lat && !errored) begin
                bus_ack_in = 1'b0;
                @(negedge clk);
                checkOutput("wait_stb", 32'(bus_stb_o), 32'h1);
                checkOutput("wait_ack", 32'(m_ack_o), 32'h0);
                checkOutput("wait_err", 32'(m_err_o), 32'h0);
                checkOutput("wait_grant", 32'(grant_o), 32'(wmask));
                tick();
                waits++;
                if (waits == TIMEOUT) errored = 1'b1;
            end
            if (errored) begin
                @(negedge clk);
                checkOutput("err_pulse", 32'(m_err_o), 32'(wmask));
                checkOutput("err_bus_cyc", 32'(bus_cyc_o), 32'h0);
                checkOutput("err_bus_stb", 32'(bus_stb_o), 32'h0);
                checkOutput("err_ack", 32'(m_ack_o), 32'h0);
                tick();
            end else begin
                rdata      = $urandom();
                bus_dat_in = rdata;
                bus_ack_in = 1'b1;
                @(negedge clk);
                checkOutput("ack_vec", 32'(m_ack_o), 32'(wmask));
                checkOutput("ack_rdata", m_dat_o, rdata);
                checkOutput("ack_err", 32'(m_err_o), 32'h0);
                checkOutput("ack_bus_cyc", 32'(bus_cyc_o), 32'h1);
                checkOutput("ack_adr", bus_adr_o, m_adr[32*w +: 32]);
                checkOutput("ack_wdat", bus_dat_o, m_dat[32*w +: 32]);
                checkOutput("ack_we", 32'(bus_we_o), 32'(m_we[w]));
                checkOutput("ack_sel", 32'(bus_sel_o), 32'(m_sel[4*w +: 4]));
                checkOutput("ack_grant", 32'(grant_o), 32'(wmask));
                tick();
                bus_ack_in = 1'b0;
            end
        end
        if (!errored) begin
            m_cyc[w] = 1'b0;
            m_stb[w] = 1'b0;
            @(negedge clk);
            checkOutput("drop_bus_cyc", 32'(bus_cyc_o), 32'h0);
            checkOutput("drop_grant", 32'(grant_o), 32'(wmask));
            checkOutput("drop_err", 32'(m_err_o), 32'h0);
            tick();
        end
    endtask

    // Start a transfer for master 2, then pull reset low between edges.
    task automatic midReset();
        logic [N-1:0] mask;
        logic [N-1:0] wmask;
        int           w;
        mask = 4'b0100;
        for (int k = 0; k < N; k++) begin
            m_cyc[k] = mask[k];
            m_stb[k] = mask[k];
            load_master(k, 1'b0);
        end
        bus_ack_in = 1'b0;
        w = model_pick(mask);
        wmask    = '0;
        wmask[w] = 1'b1;
        tick();
        bus_ack_in = 1'b1;
        #1;
        checkOutput("pre_reset_ack", 32'(m_ack_o), 32'(wmask));
        checkOutput("pre_reset_bus_cyc", 32'(bus_cyc_o), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_bus_cyc", 32'(bus_cyc_o), 32'h0);
        checkOutput("async_rst_grant", 32'(grant_o), 32'h0);
        checkOutput("async_rst_ack", 32'(m_ack_o), 32'h0);
        checkOutput("async_rst_bus_stb", 32'(bus_stb_o), 32'h0);
        bus_ack_in = 1'b0;
        m_cyc      = '1;
        tick();
        tick();
        rst      = 1'b1;
        last_idx = N - 1;
    endtask

    // Directed scenarios first, then randomized transfers.
    initial begin
        logic [N-1:0] msk;
        int           gap;
        total_checks = 0;
        pass_checks  = 0;
        fail_checks  = 0;
        last_idx     = N - 1;
        rst          = 1'b0;
        m_cyc        = '1;
        m_stb        = '1;
        m_we         = '0;
        m_sel        = '0;
        m_adr        = '0;
        m_dat        = '0;
        bus_ack_in   = 1'b0;
        bus_dat_in   = '0;

        #2;
        checkOutput("reset_grant", 32'(grant_o), 32'h0);
        checkOutput("reset_bus_cyc", 32'(bus_cyc_o), 32'h0);
        checkOutput("reset_bus_stb", 32'(bus_stb_o), 32'h0);
        checkOutput("reset_ack", 32'(m_ack_o), 32'h0);
        checkOutput("reset_err", 32'(m_err_o), 32'h0);
        checkOutput("reset_adr", bus_adr_o, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_hold_grant", 32'(grant_o), 32'h0);
        checkOutput("reset_hold_bus_cyc", 32'(bus_cyc_o), 32'h0);
        tick();
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus('1, 1, 0, 0, 1'b0);
        end
        applyStimulus(4'b1010, 3, 1, 0, 1'b0);
        applyStimulus(4'b1000, 1, 0, 0, 1'b0);
        applyStimulus(4'b0100, 2, 0, 0, 1'b1);

        applyStimulus(4'b0011, 1, TIMEOUT, 0, 1'b0);
        applyStimulus(4'b0011, 1, TIMEOUT - 1, 0, 1'b0);
        applyStimulus(4'b0001, 2, 0, TIMEOUT + 2, 1'b0);

        midReset();
        applyStimulus('1, 1, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            msk = N'($urandom_range(1, (1 << N) - 1));
            gap = ($urandom_range(0, 3) == 0) ? TIMEOUT + 1 : 0;
            applyStimulus(msk, int'($urandom_range(1, 3)), -1, gap, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
